// File: rtl/buzzer_pkg.sv
// buzzer_pkg: types and defaults shared by the buzzer driver and the frequency-select front end
package buzzer_pkg;
  localparam int CMP_W   = 22;
  localparam int MIN_CMP = 2500;
  localparam int RST_CMP = 250000;
  typedef logic [CMP_W-1:0] cmp_t;
  typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;
endpackage

// File: rtl/buzzer_half_period_ctr.sv
// buzzer_half_period_ctr: half-period counter with clamped compare reload and tone toggle
module buzzer_half_period_ctr #(
  parameter int MIN_CMP = buzzer_pkg::MIN_CMP,
  parameter int RST_CMP = buzzer_pkg::RST_CMP
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              i_start,
  input  logic              i_tick,
  input  logic              i_stay,
  input  buzzer_pkg::cmp_t  i_cmp,
  output logic              o_tone_nxt,
  output logic              o_reload
);
  import buzzer_pkg::*;
  cmp_t r_cnt, r_cmp_q, w_eff;
  logic r_tone, r_reload, w_bnd, w_load;
  always_comb begin
    w_eff      = (i_cmp < cmp_t'(MIN_CMP)) ? cmp_t'(MIN_CMP) : i_cmp;
    w_bnd      = r_cnt == r_cmp_q - 1'b1;
    w_load     = i_start | (i_tick & w_bnd);
    o_tone_nxt = i_start | (i_stay & (r_tone ^ w_bnd));
  end
  // compare value is only sampled at a boundary so a running half-period keeps its length
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt    <= '0;
      r_cmp_q  <= cmp_t'(RST_CMP);
      r_tone   <= 1'b0;
      r_reload <= 1'b0;
    end else begin
      r_cnt    <= (i_stay & ~w_bnd) ? r_cnt + 1'b1 : '0;
      r_cmp_q  <= w_load ? w_eff : r_cmp_q;
      r_tone   <= o_tone_nxt;
      r_reload <= w_load;
    end
  end
  assign o_reload = r_reload;
endmodule

// File: rtl/buzzer_tone_gen.sv
// buzzer_tone_gen: active-low piezo square-wave driver with optional on/off beep cadence
module buzzer_tone_gen #(
  parameter int MIN_CMP    = buzzer_pkg::MIN_CMP,
  parameter int RST_CMP    = buzzer_pkg::RST_CMP,
  parameter int ON_CYCLES  = 25000000,
  parameter int OFF_CYCLES = 25000000
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             enable_i,
  input  logic             beep_mode_i,
  input  buzzer_pkg::cmp_t cmp_freq_i,
  output logic             buzzer_n_o,
  output logic             active_o,
  output logic             cmp_reload_o
);
  import buzzer_pkg::*;
  localparam int CAD_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CAD_W   = $clog2(CAD_MAX);
  state_t r_state, w_nstate;
  logic [CAD_W-1:0] r_cad;
  logic r_buzzer_n, r_active, w_tone_nxt, w_start, w_tick, w_stay, w_count;
  always_comb begin
    w_nstate = !enable_i ? IDLE :
               (r_state == IDLE) ? TONE :
               (r_state == TONE) ? ((beep_mode_i && r_cad == CAD_W'(ON_CYCLES - 1)) ? GAP : TONE) :
               ((r_cad == CAD_W'(OFF_CYCLES - 1) || !beep_mode_i) ? TONE : GAP);
    w_start  = (w_nstate == TONE) && (r_state != TONE);
    w_tick   = (r_state == TONE) && enable_i;
    w_stay   = (r_state == TONE) && (w_nstate == TONE);
    w_count  = (w_nstate == r_state) && ((r_state == GAP) || (r_state == TONE && beep_mode_i));
  end
  buzzer_half_period_ctr #(.MIN_CMP(MIN_CMP), .RST_CMP(RST_CMP)) u_hp (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .i_start    (w_start),
    .i_tick     (w_tick),
    .i_stay     (w_stay),
    .i_cmp      (cmp_freq_i),
    .o_tone_nxt (w_tone_nxt),
    .o_reload   (cmp_reload_o)
  );
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= IDLE;
      r_cad      <= '0;
      r_buzzer_n <= 1'b1;
      r_active   <= 1'b0;
    end else begin
      r_state    <= w_nstate;
      r_cad      <= w_count ? r_cad + 1'b1 : '0;
      r_buzzer_n <= ~((w_nstate == TONE) && w_tone_nxt);
      r_active   <= w_nstate != IDLE;
    end
  end
  assign buzzer_n_o = r_buzzer_n;
  assign active_o   = r_active;
endmodule
